// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_e   : loader FSM states (FILL is only reachable when the build
//               defines LOADER_ZEROFILL_EN)
//   RAM_DEPTH : number of bytes in the target RAM image
//   ZERO_BYTE : value written by the zero-fill pass
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_FETCH  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FILL   = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  localparam int         RAM_DEPTH = 16;
  localparam logic [7:0] ZERO_BYTE = 8'h00;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: bus-master sequencer that copies a byte stream from a
// valid/ready source into the RAM over the shared system bus. The CPU is
// frozen (cpu_hold) for the whole load; each byte costs an address phase
// (bus_out=address, mar_wr) and a data phase (bus_out=byte, ram_wr).
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           one-cycle load request, honoured only when idle
//   in_data/in_valid/in_last/in_ready
//                   byte source handshake
//   bus_out/bus_drive  value and enable for the shared bus
//   mar_wr, ram_wr  MAR load and RAM write strobes
//   cpu_hold        holds the CPU in reset and masks its control word
//   busy, done      loader active / one-cycle completion pulse
//   err             sticky: image filled all addresses without in_last
//   load_count      bytes taken from the source in the current/last load
//   dbg_state       current FSM state
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is a pure decode of the FETCH state and
// never depends on in_valid; in_valid outside FETCH is ignored.
//
// Build option: LOADER_ZEROFILL_EN adds a FILL pass that writes ZERO_BYTE
// to every address after the one carrying in_last.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              mar_wr,
  output logic              ram_wr,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_count,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   bus_out_q, bus_out_d;
  logic                bus_drive_q, bus_drive_d;
  logic                mar_wr_q, mar_wr_d;
  logic                ram_wr_q, ram_wr_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
`ifdef LOADER_ZEROFILL_EN
  // FILL alternates an address phase (0) and a zero-write phase (1).
  logic                phase_q, phase_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef LOADER_ZEROFILL_EN
    phase_d = phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HOLD;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_HOLD:  state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (in_valid) begin
          byte_d  = in_data;
          last_d  = in_last;
          count_d = count_q + (ADDR_W+1)'(1);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_q) begin
`ifdef LOADER_ZEROFILL_EN
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            phase_d = 1'b0;
            state_d = ST_FILL;
          end else begin
            state_d = ST_FINISH;
          end
`else
          state_d = ST_FINISH;
`endif
        end else if (addr_q == LAST_ADDR) begin
          // Image is full but the source never flagged its last byte.
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_ADDR;
        end
      end
`ifdef LOADER_ZEROFILL_EN
      ST_FILL: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          phase_d = 1'b0;
        end
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered strobes line
  // up with the state they belong to; address and data phases are mutually
  // exclusive by construction.
  always_comb begin
    mar_wr_d = (state_d == ST_ADDR);
    ram_wr_d = (state_d == ST_WRITE);
`ifdef LOADER_ZEROFILL_EN
    if (state_d == ST_FILL) begin
      mar_wr_d = !phase_d;
      ram_wr_d = phase_d;
    end
`endif
    bus_drive_d = mar_wr_d | ram_wr_d;
    if (mar_wr_d) begin
      bus_out_d = DATA_W'(addr_d);
    end else if (state_d == ST_WRITE) begin
      bus_out_d = byte_d;
    end else begin
      bus_out_d = ZERO_BYTE;
    end
    // cpu_hold is released in FINISH so the CPU restarts with done.
    cpu_hold_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d     = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
      bus_out_q   <= '0;
      bus_drive_q <= 1'b0;
      mar_wr_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_ZEROFILL_EN
      phase_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      count_q     <= count_d;
      err_q       <= err_d;
      bus_out_q   <= bus_out_d;
      bus_drive_q <= bus_drive_d;
      mar_wr_q    <= mar_wr_d;
      ram_wr_q    <= ram_wr_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
`ifdef LOADER_ZEROFILL_EN
      phase_q     <= phase_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_FETCH);
  assign busy       = (state_q != ST_IDLE);
  assign bus_out    = bus_out_q;
  assign bus_drive  = bus_drive_q;
  assign mar_wr     = mar_wr_q;
  assign ram_wr     = ram_wr_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign load_count = count_q;
  assign dbg_state  = state_q;

endmodule
